// File: rtl/dac_sample_feeder.sv
// Buffers incoming audio samples and ramps the DAC output linearly
// from one sample to the next on a fixed tick grid.
module dac_sample_feeder #(
    parameter int FIFO_DEPTH   = 16,
    parameter int TICK_DIV     = 1000,
    parameter int INTERP_SHIFT = 3
) (
    input  logic                          clk_in,
    input  logic                          RST,
    input  logic signed [31:0]            data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic signed [31:0]            data_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = INTERP_SHIFT + 1;

    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'((1 << INTERP_SHIFT) - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RAMP
    } state_t;

    state_t state;

    logic signed [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic signed [31:0] fifo_head;

    logic [TW-1:0]      tick_cnt;
    logic               tick;

    logic signed [31:0] target_r;
    logic signed [31:0] step_r;
    logic [SW-1:0]      sub_cnt;
    logic signed [32:0] diff;
    logic signed [31:0] step_next;

    assign data_ready = (fifo_level != FULL);
    assign push       = data_valid && data_ready;
    assign pop        = (state == LOAD);
    assign fifo_head  = mem[rd_ptr];

    // One extra bit keeps the difference exact before the shift.
    assign diff      = {fifo_head[31], fifo_head} - {data_out[31], data_out};
    assign step_next = 32'(diff >>> INTERP_SHIFT);

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + (AW + 1)'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            data_out <= '0;
            target_r <= '0;
            step_r   <= '0;
            sub_cnt  <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fifo_level != '0) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    target_r <= fifo_head;
                    step_r   <= step_next;
                    sub_cnt  <= '0;
                    state    <= RAMP;
                end
                RAMP: begin
                    if (tick) begin
                        // Land exactly on the target to drop shift residue.
                        if (sub_cnt == SUB_LAST) begin
                            data_out <= target_r;
                            if (fifo_level != '0) begin
                                state <= LOAD;
                            end else begin
                                state    <= IDLE;
                                underrun <= 1'b1;
                            end
                        end else begin
                            data_out <= data_out + step_r;
                            sub_cnt  <= sub_cnt + SW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed bench for dac_sample_feeder with TICK_DIV=4,
// INTERP_SHIFT=2, FIFO_DEPTH=16.
module tb_dac_sample_feeder;

    logic               clk_in = 1'b0;
    logic               RST = 1'b1;
    logic signed [31:0] data_in = '0;
    logic               data_valid = 1'b0;
    logic               data_ready;
    logic signed [31:0] data_out;
    logic               underrun;
    logic [4:0]         fifo_level;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0]      sample;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t vecs [6];

    dac_sample_feeder #(
        .FIFO_DEPTH  (16),
        .TICK_DIV    (4),
        .INTERP_SHIFT(2)
    ) dut (
        .clk_in    (clk_in),
        .RST       (RST),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_out  (data_out),
        .underrun  (underrun),
        .fifo_level(fifo_level)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name,
                       input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int s,
                           input int e0, input int e1,
                           input int e2, input int e3);
        vecs[i].sample = s;
        vecs[i].exp[0] = e0;
        vecs[i].exp[1] = e1;
        vecs[i].exp[2] = e2;
        vecs[i].exp[3] = e3;
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1 RST = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 RST = 1'b0;
    endtask

    task automatic push(input logic signed [31:0] v);
        for (int k = 0; k < 50 && !data_ready; k++) begin
            @(posedge clk_in);
            #1;
        end
        data_in = v;
        data_valid = 1'b1;
        @(posedge clk_in);
        #1 data_valid = 1'b0;
    endtask

    task automatic wait_change(output int gap, output logic ok);
        logic signed [31:0] prev;
        prev = data_out;
        gap = 0;
        ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_in);
            #1;
            gap++;
            if (data_out !== prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_value(input string name,
                              input logic signed [31:0] v);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (data_out === v) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_in);
            #1;
        end
        chk({name, " reached"}, 32'(ok), 32'sd1);
    endtask

    initial begin
        int   gap;
        logic ok;
        int   cnt;
        int   be [8];
        logic signed [31:0] fin;

        set_vec(0, 7, 1, 2, 3, 7);
        set_vec(1, 400, 105, 203, 301, 400);
        set_vec(2, -400, 200, 0, -200, -400);
        set_vec(3, -7, -302, -204, -106, -7);
        set_vec(4, 2147483647, 536870906, 1073741819,
                1610612732, 2147483647);
        set_vec(5, 32'sh8000_0000, 1073741823, -1,
                -1073741825, 32'sh8000_0000);

        repeat (2) @(posedge clk_in);
        #1;
        chk("rst data_out", data_out, 0);
        chk("rst fifo_level", 32'(fifo_level), 0);
        chk("rst data_ready", 32'(data_ready), 1);
        chk("rst underrun", 32'(underrun), 0);
        #1 RST = 1'b0;

        for (int i = 0; i < 6; i++) begin
            push(vecs[i].sample);
            for (int j = 0; j < 4; j++) begin
                wait_change(gap, ok);
                chk($sformatf("vec%0d.%0d change", i, j), 32'(ok), 1);
                chk($sformatf("vec%0d.%0d value", i, j),
                    data_out, vecs[i].exp[j]);
                if (j > 0) begin
                    chk($sformatf("vec%0d.%0d gap", i, j), gap, 4);
                end
                chk($sformatf("vec%0d.%0d underrun", i, j),
                    32'(underrun), (j == 3) ? 1 : 0);
            end
            fin = vecs[i].exp[3];
            @(posedge clk_in);
            #1 chk($sformatf("vec%0d underrun clr", i), 32'(underrun), 0);
            repeat (6) @(posedge clk_in);
            #1 chk($sformatf("vec%0d idle hold", i), data_out, fin);
        end

        do_reset();
        be = '{100, 200, 300, 400, 200, 0, -200, -400};
        data_in = 400;
        data_valid = 1'b1;
        @(posedge clk_in);
        #1 data_in = -400;
        @(posedge clk_in);
        #1 data_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            wait_change(gap, ok);
            chk($sformatf("b2b.%0d change", j), 32'(ok), 1);
            chk($sformatf("b2b.%0d value", j), data_out, be[j]);
            if (j > 0) begin
                chk($sformatf("b2b.%0d gap", j), gap, 4);
            end
            chk($sformatf("b2b.%0d underrun", j),
                32'(underrun), (j == 7) ? 1 : 0);
        end

        do_reset();
        push(400);
        push(800);
        wait_value("midrst 200", 200);
        #2 RST = 1'b1;
        #1;
        chk("midrst data_out", data_out, 0);
        chk("midrst fifo_level", 32'(fifo_level), 0);
        chk("midrst data_ready", 32'(data_ready), 1);
        chk("midrst underrun", 32'(underrun), 0);
        @(posedge clk_in);
        #1 RST = 1'b0;
        repeat (6) @(posedge clk_in);
        #1;
        chk("postrst data_out", data_out, 0);
        chk("postrst fifo_level", 32'(fifo_level), 0);
        push(1200);
        be[0:3] = '{300, 600, 900, 1200};
        for (int j = 0; j < 4; j++) begin
            wait_change(gap, ok);
            chk($sformatf("postrst.%0d change", j), 32'(ok), 1);
            chk($sformatf("postrst.%0d value", j), data_out, be[j]);
        end

        do_reset();
        repeat (2) @(posedge clk_in);
        #1 data_valid = 1'b1;
        for (int p = 0; p < 6; p++) begin
            data_in = 1000 * (p + 1);
            @(posedge clk_in);
            #1;
        end
        data_valid = 1'b0;
        chk("pp level before", 32'(fifo_level), 5);
        repeat (12) @(posedge clk_in);
        #1;
        chk("pp first target", data_out, 1000);
        chk("pp level at final", 32'(fifo_level), 5);
        chk("pp no underrun", 32'(underrun), 0);
        data_in = 7000;
        data_valid = 1'b1;
        @(posedge clk_in);
        #1 data_valid = 1'b0;
        chk("pp level push+pop", 32'(fifo_level), 5);
        for (int p = 1; p < 7; p++) begin
            wait_value($sformatf("pp order %0d", p), 1000 * (p + 1));
        end

        do_reset();
        repeat (2) @(posedge clk_in);
        #1;
        cnt = 0;
        data_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            data_in = 1000 * (cnt + 1);
            if (data_ready) begin
                cnt++;
            end
            @(posedge clk_in);
            #1;
            if (fifo_level == 5'd16) begin
                break;
            end
        end
        data_valid = 1'b0;
        chk("fill accepted", cnt, 17);
        chk("fill level", 32'(fifo_level), 16);
        chk("fill data_ready", 32'(data_ready), 0);
        for (int p = 0; p < 17; p++) begin
            wait_value($sformatf("fill order %0d", p), 1000 * (p + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_sample_feeder.md
DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: input sample buffer depth, a power of 2, 4..64.
REQ-002 SHALL have parameter TICK_DIV, default 1000: clk_in cycles per output update tick, at least 2.
REQ-003 SHALL have parameter INTERP_SHIFT, default 3: each input sample spans 2^INTERP_SHIFT ticks, range 0..8.
REQ-004 Port clk_in, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port data_in, input, signed 32 bits: incoming audio sample.
REQ-007 Port data_valid, input, 1 bit: data_in is valid this cycle.
REQ-008 Port data_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 Port data_out, output, signed 32 bits: interpolated sample driven to the PWM DAC data input.
REQ-010 Port underrun, output, 1 bit: one-cycle pulse when a ramp ends with the FIFO empty.
REQ-011 Port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-012 Push handshake: a push occurs when data_valid && data_ready.
REQ-013 data_ready SHALL equal (fifo_level != FIFO_DEPTH), derived combinationally from registered occupancy.
REQ-014 A push and a pop in the same cycle SHALL leave fifo_level unchanged and preserve order.
REQ-015 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 Tick counter:
- free-runs 0..TICK_DIV-1 regardless of state;
- tick pulse is asserted in the cycle the counter equals TICK_DIV-1.
REQ-017 FSM states and transitions:
- IDLE -> LOAD when fifo_level != 0;
- LOAD -> RAMP unconditionally after 1 cycle;
- RAMP -> LOAD or IDLE after the final sub-step (see REQ-020).
REQ-018 In LOAD, the block SHALL:
- pop one sample into target_r;
- compute step_r = (target_r - data_out) as 33-bit signed, arithmetic right shift by INTERP_SHIFT, truncated to 32 bits;
- clear sub_cnt.
REQ-019 In RAMP, on each tick that is not the final sub-step: data_out <= data_out + step_r (32-bit wrap-free, guaranteed by REQ-018), sub_cnt increments.
REQ-020 Final sub-step is the tick when sub_cnt == 2^INTERP_SHIFT-1. On it:
- data_out <= target_r exactly, discarding rounding residue;
- next state is LOAD if the FIFO is non-empty, else IDLE with underrun pulsed for 1 cycle.
REQ-021 When INTERP_SHIFT == 0, every RAMP tick is final: data_out steps directly to target_r.
REQ-022 data_out SHALL hold its value in IDLE and LOAD and on non-tick RAMP cycles.
REQ-023 Latency: a sample pushed into an empty FIFO while in IDLE SHALL reach LOAD 1 cycle after the push; ramp progress then follows the tick grid.
REQ-024 A push arriving in the same cycle as a final sub-step SHALL be visible to the REQ-020 decision only from the next cycle (registered level); underrun MAY pulse in that case.

Reset
REQ-025 RST asserted at any time, including mid-ramp, SHALL asynchronously clear:
- FSM to IDLE;
- data_out, target_r, step_r, sub_cnt, tick counter, FIFO pointers and fifo_level to 0;
- underrun to 0.
REQ-026 During reset, data_ready SHALL be 1; FIFO contents need not be cleared.
REQ-027 After RST deasserts, the first sample SHALL ramp from 0.

Verification (TICK_DIV=4, INTERP_SHIFT=2, FIFO_DEPTH=16)
REQ-028 Push 400 after reset -> data_out 100, 200, 300, 400 on consecutive ticks, then IDLE, underrun pulses once.
REQ-029 Push 400 then -400 back-to-back -> after reaching 400, data_out goes 200, 0, -200, -400 with no IDLE between samples.
REQ-030 Push 7 from 0 -> data_out 1, 2, 3, then exactly 7.
REQ-031 Hold data_valid=1 for 20 cycles with no tick progress possible -> FIFO fills; after the first LOAD pop, 16 more pushes are accepted (17 total); data_ready=0 at fifo_level 16; no overwrite.
REQ-032 Assert RST mid-ramp at data_out=200 -> data_out=0, fifo_level=0, FSM in IDLE immediately; next sample ramps from 0.
REQ-033 Simultaneous push and pop at fifo_level 5 -> fifo_level stays 5; output order matches push order.
